// File: rtl/multiplicador_sequencial.sv
// rtl/multiplicador_sequencial.sv - radix-2 shift-add sequential multiplier, unsigned or two's complement
module multiplicador_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               last_bit;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result;

    // Magnitudes are taken at acceptance; -2^(WIDTH-1) negates to itself, which is
    // exactly the correct unsigned magnitude.
    assign a_neg = signed_mode & A[WIDTH-1];
    assign b_neg = signed_mode & B[WIDTH-1];
    assign a_mag = a_neg ? (~A + WIDTH'(1)) : A;
    assign b_mag = b_neg ? (~B + WIDTH'(1)) : B;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign addend   = {{WIDTH{1'b0}}, mcand} << cnt;
    assign acc_sum  = mplier[0] ? (acc + addend) : acc;
    assign result   = neg ? (~acc + (2*WIDTH)'(1)) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Status and product are registered from the state, so they trail it by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            P    <= '0;
        end else begin
            busy <= (state != IDLE);
            done <= (state == DONE);
            if (state == DONE) begin
                P <= result;
            end
        end
    end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// tb/tb_multiplicador_sequencial.sv - directed self-checking bench for multiplicador_sequencial
module tb_multiplicador_sequencial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [7:0]  A, B;
    logic        busy, done;
    logic [15:0] P;

    int checks   = 0;
    int failures = 0;

    multiplicador_sequencial #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .P           (P)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble the inputs afterwards, and time the done pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp);
        int n;
        A = a; B = b; signed_mode = sm; start = 1'b1;
        step();
        start = 1'b0;
        A = ~a; B = b ^ 8'h5A; signed_mode = ~sm;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_p"}, 32'(P), 32'(exp));
        step();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        logic [15:0] p_first;
        logic [15:0] p_second;
        int stray;

        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", 32'(P), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
        for (int i = 0; i < 5; i++) step();
        check("u13x11_hold", 32'(P), 32'h008F);

        run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01);
        run_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run_op("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("s_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080);
        run_op("zero", 8'd0, 8'd200, 1'b0, 16'h0000);

        // start held high; operands change while the first product is in progress
        A = 8'd2; B = 8'd3; signed_mode = 1'b0; start = 1'b1;
        step();
        pulses = 0; first_at = 0; second_at = 0; p_first = '0; p_second = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 3) begin
                A = 8'd5; B = 8'd7;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = i; p_first = P;
                end else if (pulses == 2) begin
                    second_at = i; p_second = P;
                end
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd2);
        check("held_first_at", 32'(first_at), 32'd9);
        check("held_p1", 32'(p_first), 32'd6);
        check("held_gap", 32'(second_at - first_at), 32'd10);
        check("held_p2", 32'(p_second), 32'd35);
        for (int i = 0; i < 12; i++) step();
        check("held_drain", 32'(busy), 32'd0);

        // reset in the middle of CALC aborts without a done pulse
        A = 8'd100; B = 8'd100; signed_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_p", 32'(P), 32'd0);
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) stray++;
        end
        check("abort_no_done", 32'(stray), 32'd0);
        check("abort_p_kept", 32'(P), 32'd0);

        run_op("u7x9", 8'd7, 8'd9, 1'b0, 16'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
